alu_cmd_issuer: RTL and testbench



---
 rtl/alu_cmd_issuer_if.sv | 46 ++++
 rtl/alu_cmd_issuer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the issuer's command, ALU, response and statistics signals.
// The issuer connects through the slave modport; the surrounding logic uses master.
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_a_valid;
  logic             cmd_b_valid;
  logic [15:0]      cmd_m1;
  logic [15:0]      cmd_m2;
  logic [1:0]       alu_operation;
  logic             alu_a_valid;
  logic             alu_b_valid;
  logic             alu_start;
  logic [15:0]      alu_m1;
  logic [15:0]      alu_m2;
  logic             alu_valid;
  logic             alu_error;
  logic [47:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [47:0]      rsp_result;
  logic             rsp_error;
  logic             rsp_timeout;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      done_count;
  logic [15:0]      err_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a_valid, cmd_b_valid, cmd_m1, cmd_m2,
    input  alu_valid, alu_error, alu_result, rsp_ready,
    output cmd_ready, alu_operation, alu_a_valid, alu_b_valid, alu_start,
    output alu_m1, alu_m2, rsp_valid, rsp_result, rsp_error, rsp_timeout,
    output rsp_tag, done_count, err_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a_valid, cmd_b_valid, cmd_m1, cmd_m2,
    output alu_valid, alu_error, alu_result, rsp_ready,
    input  cmd_ready, alu_operation, alu_a_valid, alu_b_valid, alu_start,
    input  alu_m1, alu_m2, rsp_valid, rsp_result, rsp_error, rsp_timeout,
    input  rsp_tag, done_count, err_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Requester front end for the complex ALU: issues one command at a time,
// waits for completion or timeout, and returns a tagged response with statistics.
module alu_cmd_issuer #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_cmd_issuer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [1:0]       r_alu_op;
  logic             r_alu_a_valid;
  logic             r_alu_b_valid;
  logic             r_alu_start;
  logic [15:0]      r_alu_m1;
  logic [15:0]      r_alu_m2;
  logic             r_rsp_valid;
  logic [47:0]      r_rsp_result;
  logic             r_rsp_error;
  logic             r_rsp_timeout;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [15:0]      r_done_count;
  logic [15:0]      r_err_count;
  logic             w_complete;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign w_complete = bus.alu_valid | bus.alu_error;

  // Issue/complete/respond sequencer; every output below is a register or a state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 16'd0;
      r_alu_op      <= 2'd0;
      r_alu_a_valid <= 1'b0;
      r_alu_b_valid <= 1'b0;
      r_alu_start   <= 1'b0;
      r_alu_m1      <= 16'd0;
      r_alu_m2      <= 16'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= 48'd0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_tag     <= '0;
      r_done_count  <= 16'd0;
      r_err_count   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_alu_op      <= bus.cmd_op;
            r_alu_a_valid <= bus.cmd_a_valid;
            r_alu_b_valid <= bus.cmd_b_valid;
            r_alu_m1      <= bus.cmd_m1;
            r_alu_m2      <= bus.cmd_m2;
            r_alu_start   <= 1'b1;
            r_cnt         <= 16'd0;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Completion wins over a timeout landing in the same cycle.
          if (w_complete || (r_cnt == TO_LAST)) begin
            r_rsp_result  <= w_complete ? bus.alu_result : 48'd0;
            r_rsp_error   <= bus.alu_error;
            r_rsp_timeout <= ~w_complete;
            r_rsp_valid   <= 1'b1;
            r_alu_op      <= 2'd0;
            r_alu_a_valid <= 1'b0;
            r_alu_b_valid <= 1'b0;
            r_alu_m1      <= 16'd0;
            r_alu_m2      <= 16'd0;
            r_alu_start   <= 1'b0;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= sat_inc(r_done_count);
            if (r_rsp_error || r_rsp_timeout) begin
              r_err_count <= sat_inc(r_err_count);
            end
            r_rsp_tag    <= r_rsp_tag + TAG_W'(1);
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_alu_start <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = (r_state == ST_IDLE);
  assign bus.alu_operation = r_alu_op;
  assign bus.alu_a_valid   = r_alu_a_valid;
  assign bus.alu_b_valid   = r_alu_b_valid;
  assign bus.alu_start     = r_alu_start;
  assign bus.alu_m1        = r_alu_m1;
  assign bus.alu_m2        = r_alu_m2;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_error     = r_rsp_error;
  assign bus.rsp_timeout   = r_rsp_timeout;
  assign bus.rsp_tag       = r_rsp_tag;
  assign bus.done_count    = r_done_count;
  assign bus.err_count     = r_err_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small ALU model that completes a
// programmable number of start cycles after issue (0 = never).
module tb_alu_cmd_issuer;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   alu_delay;
  logic alu_err_mode;
  int   seen;
  int   low_run;
  int   min_gap;
  logic had_start;

  alu_cmd_issuer_if #(.TAG_W(4)) bus ();

  alu_cmd_issuer #(.TIMEOUT(8), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: result = m1 + m2 + (op << 32)
  assign bus.alu_valid  = bus.alu_start && (alu_delay != 0) && (seen == alu_delay - 1);
  assign bus.alu_error  = bus.alu_valid && alu_err_mode;
  assign bus.alu_result = 48'(bus.alu_m1) + 48'(bus.alu_m2) + {14'd0, bus.alu_operation, 32'd0};

  always @(posedge clk) begin
    seen <= bus.alu_start ? seen + 1 : 0;
  end

  // Track the shortest low stretch of alu_start between two operations.
  always @(posedge clk) begin
    if (bus.alu_start) begin
      if (had_start && low_run > 0 && low_run < min_gap) min_gap <= low_run;
      had_start <= 1'b1;
      low_run   <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] m1, input logic [15:0] m2);
    int n;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a_valid = 1'b1;
    bus.cmd_b_valid = 1'b1;
    bus.cmd_m1      = m1;
    bus.cmd_m2      = m2;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    check("accept_start", 64'(bus.alu_start), 64'd1);
  endtask

  task automatic wait_resp(output int starts);
    starts = 0;
    while (bus.alu_start && starts < 100) begin
      starts++;
      tick();
    end
  endtask

  initial begin
    int st;
    logic [1:0]  ops [4];
    logic [47:0] exps [4];
    n_tests = 0;
    n_fail = 0;
    alu_delay = 3;
    alu_err_mode = 1'b0;
    seen = 0;
    low_run = 0;
    min_gap = 1000;
    had_start = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_a_valid = 1'b0;
    bus.cmd_b_valid = 1'b0;
    bus.cmd_m1 = 16'd0;
    bus.cmd_m2 = 16'd0;
    bus.rsp_ready = 1'b0;
    do_reset();

    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_alu_start", 64'(bus.alu_start), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_tag", 64'(bus.rsp_tag), 64'd0);
    check("rst_done", 64'(bus.done_count), 64'd0);

    // Basic op: 3 + 4 = 7 after three start cycles
    send_cmd(2'd0, 16'h0003, 16'h0004);
    check("basic_m1", 64'(bus.alu_m1), 64'h3);
    check("basic_a_valid", 64'(bus.alu_a_valid), 64'd1);
    wait_resp(st);
    check("basic_starts", 64'(st), 64'd3);
    check("basic_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("basic_result", 64'(bus.rsp_result), 64'h7);
    check("basic_error", 64'(bus.rsp_error), 64'd0);
    check("basic_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("basic_tag", 64'(bus.rsp_tag), 64'd0);
    check("basic_alu_m1_idle", 64'(bus.alu_m1), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("basic_done", 64'(bus.done_count), 64'd1);
    check("basic_err", 64'(bus.err_count), 64'd0);
    check("basic_ready_back", 64'(bus.cmd_ready), 64'd1);

    // Back-to-back with rsp_ready tied high, fresh tags from 0
    do_reset();
    alu_delay = 1;
    bus.rsp_ready = 1'b1;
    ops[0] = 2'd0; exps[0] = 48'h0000_0000_0011;
    ops[1] = 2'd3; exps[1] = 48'h0003_0000_0012;
    ops[2] = 2'd1; exps[2] = 48'h0001_0000_0013;
    ops[3] = 2'd2; exps[3] = 48'h0002_0000_0014;
    for (int i = 0; i < 4; i++) begin
      send_cmd(ops[i], 16'(i + 1), 16'h0010);
      check("b2b_op", 64'(bus.alu_operation), 64'(ops[i]));
      wait_resp(st);
      check("b2b_starts", 64'(st), 64'd1);
      check("b2b_tag", 64'(bus.rsp_tag), 64'(i));
      check("b2b_result", 64'(bus.rsp_result), 64'(exps[i]));
      tick();
    end
    check("b2b_done", 64'(bus.done_count), 64'd4);
    check("b2b_gap_ge2", 64'(min_gap >= 2), 64'd1);
    bus.rsp_ready = 1'b0;

    // Error: valid and error together, result still captured
    alu_delay = 2;
    alu_err_mode = 1'b1;
    send_cmd(2'd0, 16'h0100, 16'h0023);
    wait_resp(st);
    check("err_starts", 64'(st), 64'd2);
    check("err_flag", 64'(bus.rsp_error), 64'd1);
    check("err_result", 64'(bus.rsp_result), 64'h123);
    check("err_tag", 64'(bus.rsp_tag), 64'd4);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("err_count", 64'(bus.err_count), 64'd1);
    check("err_done", 64'(bus.done_count), 64'd5);
    alu_err_mode = 1'b0;

    // Timeout: ALU silent, start held exactly TIMEOUT=8 cycles
    alu_delay = 0;
    send_cmd(2'd2, 16'h1111, 16'h2222);
    wait_resp(st);
    check("to_starts", 64'(st), 64'd8);
    check("to_flag", 64'(bus.rsp_timeout), 64'd1);
    check("to_result", 64'(bus.rsp_result), 64'd0);
    check("to_error", 64'(bus.rsp_error), 64'd0);

    // Backpressure: hold the timeout response for 10 cycles with a command waiting
    alu_delay = 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd1;
    bus.cmd_m1 = 16'h0007;
    bus.cmd_m2 = 16'h0008;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("bp_tag", 64'(bus.rsp_tag), 64'd5);
      check("bp_timeout", 64'(bus.rsp_timeout), 64'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_ready_after", 64'(bus.cmd_ready), 64'd1);
    check("bp_err_count", 64'(bus.err_count), 64'd2);
    check("bp_done", 64'(bus.done_count), 64'd6);
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_next_start", 64'(bus.alu_start), 64'd1);
    wait_resp(st);
    check("bp_next_result", 64'(bus.rsp_result), 64'h0001_0000_000F);
    check("bp_next_tag", 64'(bus.rsp_tag), 64'd6);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset mid-BUSY drops the operation
    alu_delay = 0;
    send_cmd(2'd3, 16'h00AA, 16'h00BB);
    tick();
    rst_n = 1'b0;
    tick();
    check("rmb_alu_start", 64'(bus.alu_start), 64'd0);
    check("rmb_alu_m1", 64'(bus.alu_m1), 64'd0);
    check("rmb_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rmb_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rmb_done", 64'(bus.done_count), 64'd0);
    check("rmb_err", 64'(bus.err_count), 64'd0);
    check("rmb_tag", 64'(bus.rsp_tag), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rmb_no_rsp", 64'(bus.rsp_valid), 64'd0);
    alu_delay = 1;
    send_cmd(2'd0, 16'h0001, 16'h0001);
    wait_resp(st);
    check("rmb_next_tag", 64'(bus.rsp_tag), 64'd0);
    check("rmb_next_result", 64'(bus.rsp_result), 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
